// File: rtl/mux4_bus_arbiter.sv
// Round-robin owner of the shared 16-bit 4:1 operand mux with bounded tenure and a dead cycle between owners.
// Optional per-requester grant counters (cnt_idx/cnt_val) are built when ARB_GRANT_CNT_EN is defined.

module mux4_1 #(
    parameter int W = 16
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] y
);
    always_comb begin
        unique case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
        endcase
    end
endmodule

module mux4_bus_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] data_a,
    input  logic [15:0] data_b,
    input  logic [15:0] data_c,
    input  logic [15:0] data_d,
    output logic [3:0]  grant,
    output logic [1:0]  sel,
    output logic        bus_valid,
    output logic [15:0] bus_data
`ifdef ARB_GRANT_CNT_EN
    ,
    input  logic [1:0]       cnt_idx,
    output logic [CNT_W-1:0] cnt_val
`endif
);
    localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    typedef struct packed {
        state_t            state;
        logic [3:0]        grant;
        logic [1:0]        sel;
        logic              vld;
        logic [1:0]        rr_ptr;
        logic [HOLD_W-1:0] hold;
    } arb_t;

    arb_t       cur, nxt;
    logic [1:0] pick;
    logic       start;
    logic       expire;
    logic       others;
    logic       own_drop;

    // First requester at or after rr_ptr; lowest offset wins.
    always_comb begin
        pick = cur.rr_ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req[cur.rr_ptr + 2'(k)]) pick = cur.rr_ptr + 2'(k);
        end
    end

    assign expire   = (cur.hold == HOLD_LAST);
    assign others   = |(req & ~cur.grant);
    assign own_drop = ~req[cur.sel];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur.state  <= IDLE;
            cur.grant  <= '0;
            cur.sel    <= '0;
            cur.vld    <= 1'b0;
            cur.rr_ptr <= '0;
            cur.hold   <= '0;
        end else begin
            cur <= nxt;
        end
    end

    always_comb begin
        nxt   = cur;
        start = 1'b0;
        case (cur.state)
            IDLE, RELEASE: begin
                if (|req) begin
                    nxt.state = BUSY;
                    nxt.grant = 4'b0001 << pick;
                    nxt.sel   = pick;
                    nxt.vld   = 1'b1;
                    nxt.hold  = '0;
                    start     = 1'b1;
                end else begin
                    nxt.state = IDLE;
                    nxt.grant = '0;
                    nxt.vld   = 1'b0;
                end
            end
            BUSY: begin
                if (own_drop || (expire && others)) begin
                    nxt.state  = RELEASE;
                    nxt.grant  = '0;
                    nxt.vld    = 1'b0;
                    nxt.rr_ptr = cur.sel + 2'd1;
                    nxt.hold   = '0;
                end else if (expire) begin
                    // Sole requester: renew the tenure without a dead cycle.
                    nxt.hold = '0;
                end else begin
                    nxt.hold = cur.hold + HOLD_W'(1);
                end
            end
            default: begin
                nxt.state = IDLE;
                nxt.grant = '0;
                nxt.vld   = 1'b0;
                nxt.hold  = '0;
            end
        endcase
    end

    assign grant     = cur.grant;
    assign sel       = cur.sel;
    assign bus_valid = cur.vld;

    mux4_1 #(.W(16)) u_mux (
        .sel (cur.sel),
        .a   (data_a),
        .b   (data_b),
        .c   (data_c),
        .d   (data_d),
        .y   (bus_data)
    );

`ifdef ARB_GRANT_CNT_EN
    logic [CNT_W-1:0] gcnt [4];

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                     gcnt[g] <= '0;
            else if (start && pick == 2'(g)) gcnt[g] <= gcnt[g] + CNT_W'(1);
        end
    end

    assign cnt_val = gcnt[cnt_idx];
`else
    logic unused_start;
    assign unused_start = start;
`endif

endmodule
